instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Instruction fetch stage sitting directly upstream of the RV32 decoder.
// Holds the PC, issues word requests to instruction memory, and buffers
// returned instructions with their PCs. Presents them to decode over a
// valid/ready handshake. Accepts redirects (branch/jump targets) from
// execute and discards stale in-flight responses after a redirect.
// PARAMETERS
// n           32            instruction / address width
// RESET_PC    32'h0000_0000 PC value loaded on reset
// FIFO_DEPTH  2             instruction buffer entries; also max requests in flight
// PORTS
// clk             in   1  clock, all state on rising edge
// rst_n           in   1  asynchronous active-low reset
// imem_req_valid  out  1  fetch request valid
// imem_req_ready  in   1  memory accepts request this cycle
// imem_addr       out  n  byte address of requested word (bits [1:0] = 0)
// imem_rsp_valid  in   1  response data valid; in-order; no backpressure
// imem_rsp_data   in   n  returned instruction word
// redirect_valid  in   1  load new PC; flush the pipeline front
// redirect_pc     in   n  redirect target; bits [1:0] ignored
// instr_valid     out  1  instr/instr_pc valid toward decoder
// instr_ready     in   1  decoder consumes instruction this cycle
// instr           out  n  instruction word (feeds decoder instr input)
// instr_pc        out  n  PC of instr
// BEHAVIOUR
// - Reset (async, rst_n=0) gives the following state:
//   - pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0
//   - imem_req_valid=0, instr_valid=0, instr/instr_pc=0
// - Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
//   - Every response therefore always has a FIFO slot.
//   - First request is in the first cycle after rst_n rises.
// - imem_addr = pc while imem_req_valid=1.
// - Accept (req_valid && req_ready): pc <= pc+4 (wraps mod 2^n); outstanding++.
// - Response, discard>0: drop it; discard--; outstanding--.
// - Response, discard==0: push {rsp_pc, rsp_data}; rsp_pc <= rsp_pc+4; outstanding--.
// - instr_valid = FIFO not empty && !redirect_valid. Head is registered.
//   - Latency: rsp_valid in cycle T gives instr_valid in cycle T+1 (FIFO was empty).
//   - Latency: a request accepted in cycle T gives its earliest instr_valid in T+2.
// - Pop on instr_valid && instr_ready. Push and pop in the same cycle are allowed.
//   - Push and pop together leave the count unchanged; a full FIFO accepts push+pop.
// - Redirect cycle (redirect_valid=1), each of the following holds:
//   - pc <= {redirect_pc[n-1:2],2'b00}; rsp_pc <= the same value
//   - FIFO flushed; no pop occurs even if instr_ready=1
//   - discard <= outstanding - (rsp_valid ? 1 : 0)
//   - A response arriving in the redirect cycle is dropped.
//   - No request is issued that cycle. A withdrawn unaccepted request is legal.
// - Back-to-back redirects: the last one wins; discard recomputed from current outstanding.
// - outstanding and discard are $clog2(FIFO_DEPTH+1) bits and never over/underflow.
//   - Assertion: rsp_valid with outstanding==0 is an error.
// - Reset mid-operation: all state cleared immediately. In-flight responses after reset
//   are the memory's responsibility (memory is reset with the same rst_n).
// STRUCTURE
// - fetch_pkg holds:
//   - typedef fetch_entry_t {logic [n-1:0] pc; logic [n-1:0] instr;}
//   - localparam ILEN_BYTES=4
//   - localparam NOP_INSTR=32'h0000_0013
// - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH.
//   - Ports: push/pop/flush/full/empty/count; registered head.
// - Top holds the PC, rsp_pc and outstanding/discard counters plus the credit logic.
// TESTING
// 1. Reset release, req_ready=1, 1-cycle memory:
//    -> addresses 0x0,0x4,0x8... in order; instr_pc matches; first instr_valid 2 cycles after first accept.
// 2. instr_ready=0 for 10 cycles:
//    -> at most 2 accepts; then req_valid=0; FIFO holds PCs 0x0,0x4.
//    -> ready=1 drains in order and fetching resumes at 0x8.
// 3. Redirect to 0x103 with 2 requests outstanding:
//    -> next imem_addr=0x100; both old responses dropped; first instr_pc=0x100.
// 4. Redirect in the same cycle as a response plus instr_ready=1:
//    -> response dropped; no pop; discard = outstanding-1; FIFO empty next cycle.
// 5. pc=0xFFFF_FFFC fetched:
//    -> next imem_addr=0x0000_0000; instr_pc sequence wraps cleanly.
// 6. rst_n asserted mid-stream with a full FIFO:
//    -> outputs 0 asynchronously; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so a target always names a whole instruction word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(ILEN_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries whose head is always a register.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [FIFO_DEPTH];
    fetch_entry_t  mem_d [FIFO_DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // A simultaneous pop shifts everything down one slot before the new entry lands.
    assign wr_idx  = do_pop ? count_q - CW'(1) : count_q;
    assign head    = mem_q[0];
    assign count   = count_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            if (do_push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        mem_d[i] = din;
                    end
                end
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC generation, credit-limited memory requests, response
// buffering toward decode, and redirect handling with stale-response discard.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int           n          = 32,
    parameter logic [n-1:0] RESET_PC   = '0,
    parameter int           FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [n-1:0] imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [n-1:0] imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == CW'(FIFO_DEPTH)) ? v : v + CW'(1);
    endfunction

    function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
        return (v == '0) ? v : v - CW'(1);
    endfunction

    logic [n-1:0]  pc_q;
    logic [n-1:0]  rsp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credits_used;
    logic [n-1:0]  redirect_tgt;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;

    assign redirect_tgt = word_align(redirect_pc);

    // Every request in flight already owns a buffer slot, so responses never need backpressure.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = rst_n && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push        = imem_rsp_valid && !redirect_valid && (discard_q == '0);
    assign instr_valid = !fifo_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fetch_entry_t'{pc: rsp_pc_q, instr: imem_rsp_data}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            case ({accept, imem_rsp_valid})
                2'b10:   outstanding_q <= inc_sat(outstanding_q);
                2'b01:   outstanding_q <= dec_sat(outstanding_q);
                default: outstanding_q <= outstanding_q;
            endcase
            if (redirect_valid) begin
                pc_q      <= redirect_tgt;
                rsp_pc_q  <= redirect_tgt;
                // A response landing this cycle is already dropped, so it is not counted again.
                discard_q <= imem_rsp_valid ? dec_sat(outstanding_q) : outstanding_q;
            end else begin
                if (accept) begin
                    pc_q <= pc_q + n'(ILEN_BYTES);
                end
                if (imem_rsp_valid) begin
                    if (discard_q != '0) begin
                        discard_q <= dec_sat(discard_q);
                    end else begin
                        rsp_pc_q <= rsp_pc_q + n'(ILEN_BYTES);
                    end
                end
            end
        end
    end

    a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && outstanding_q == '0));

    a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple in-order instruction memory (data = ~addr).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .n(32),
        .RESET_PC(32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mem_on = 1'b1;
    logic [31:0] pend[$];
    logic [31:0] acc_addr[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    task automatic clear_logs();
        acc_addr.delete();
        pop_pc.delete();
        pop_instr.delete();
    endtask

    // One clock: record handshakes just before the edge, then let memory answer 1 cycle later.
    task automatic tick();
        #2;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_addr);
            acc_addr.push_back(imem_addr);
        end
        if (instr_valid && instr_ready) begin
            pop_pc.push_back(instr_pc);
            pop_instr.push_back(instr);
        end
        @(posedge clk);
        #1;
        if (mem_on && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pend.pop_front();
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        mem_on = 1'b1;
        pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL release_req_valid got=%b want=1", imem_req_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL release_addr got=%h want=0", imem_addr); end
    endtask

    task automatic test_stream();
        clear_logs();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        mem_on = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_lat1_valid got=%b want=0", instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stream_lat2_valid got=%b want=1", instr_valid); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL stream_lat2_pc got=%h want=0", instr_pc); end
        n_cmp++; if (instr !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL stream_lat2_instr got=%h want=ffffffff", instr); end
        repeat (16) tick();
        n_cmp++;
        if (acc_addr.size() < 6 || pop_pc.size() < 5) begin
            n_bad++; $display("FAIL stream_counts accepts=%0d pops=%0d want>=6/5", acc_addr.size(), pop_pc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (acc_addr[i] !== 32'(4*i)) begin n_bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, acc_addr[i], 32'(4*i)); end
            end
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (pop_pc[i] !== 32'(4*i)) begin n_bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, pop_pc[i], 32'(4*i)); end
                n_cmp++; if (pop_instr[i] !== ~32'(4*i)) begin n_bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, pop_instr[i], ~32'(4*i)); end
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] want;
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        repeat (10) tick();
        n_cmp++; if (acc_addr.size() != 2) begin n_bad++; $display("FAIL hold_accepts got=%0d want=2", acc_addr.size()); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hold_req_valid got=%b want=0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL hold_instr_valid got=%b want=1", instr_valid); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL hold_head_pc got=%h want=0", instr_pc); end
        instr_ready = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (acc_addr.size() < 3 || pop_pc.size() < 4) begin
            n_bad++; $display("FAIL hold_drain_counts accepts=%0d pops=%0d want>=3/4", acc_addr.size(), pop_pc.size());
        end else begin
            n_cmp++; if (acc_addr[2] !== 32'h8) begin n_bad++; $display("FAIL hold_resume_addr got=%h want=8", acc_addr[2]); end
            for (int i = 0; i < 4; i++) begin
                want = 32'(4*i);
                n_cmp++; if (pop_pc[i] !== want) begin n_bad++; $display("FAIL hold_drain_pc[%0d] got=%h want=%h", i, pop_pc[i], want); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        mem_on = 1'b0;
        tick();
        tick();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_credit_stall got=%b want=0", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        mem_on = 1'b1;
        clear_logs();
        repeat (12) tick();
        n_cmp++;
        if (acc_addr.size() < 1 || pop_pc.size() < 2) begin
            n_bad++; $display("FAIL redir_counts accepts=%0d pops=%0d want>=1/2", acc_addr.size(), pop_pc.size());
        end else begin
            n_cmp++; if (acc_addr[0] !== 32'h100) begin n_bad++; $display("FAIL redir_addr got=%h want=100", acc_addr[0]); end
            n_cmp++; if (pop_pc[0] !== 32'h100) begin n_bad++; $display("FAIL redir_first_pc got=%h want=100", pop_pc[0]); end
            n_cmp++; if (pop_instr[0] !== ~32'h100) begin n_bad++; $display("FAIL redir_first_instr got=%h want=%h", pop_instr[0], ~32'h100); end
            n_cmp++; if (pop_pc[1] !== 32'h104) begin n_bad++; $display("FAIL redir_second_pc got=%h want=104", pop_pc[1]); end
        end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        mem_on = 1'b1;
        tick();
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL rr_pre_valid got=%b want=1", instr_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        instr_ready = 1'b1;
        clear_logs();
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rr_valid_masked got=%b want=0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rr_req_masked got=%b want=0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (pop_pc.size() != 0) begin n_bad++; $display("FAIL rr_no_pop got=%0d pops want=0", pop_pc.size()); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rr_fifo_empty got=%b want=0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rr_req_valid got=%b want=1", imem_req_valid); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL rr_addr got=%h want=200", imem_addr); end
        repeat (8) tick();
        n_cmp++;
        if (pop_pc.size() < 1) begin
            n_bad++; $display("FAIL rr_pop_count got=%0d want>=1", pop_pc.size());
        end else begin
            n_cmp++; if (pop_pc[0] !== 32'h200) begin n_bad++; $display("FAIL rr_first_pc got=%h want=200", pop_pc[0]); end
            n_cmp++; if (pop_instr[0] !== ~32'h200) begin n_bad++; $display("FAIL rr_first_instr got=%h want=%h", pop_instr[0], ~32'h200); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        mem_on = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        repeat (16) tick();
        n_cmp++;
        if (acc_addr.size() < 4 || pop_pc.size() < 4) begin
            n_bad++; $display("FAIL wrap_counts accepts=%0d pops=%0d want>=4/4", acc_addr.size(), pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (acc_addr[i] !== exp_seq[i]) begin n_bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, acc_addr[i], exp_seq[i]); end
                n_cmp++; if (pop_pc[i] !== exp_seq[i]) begin n_bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", i, pop_pc[i], exp_seq[i]); end
                n_cmp++; if (pop_instr[i] !== ~exp_seq[i]) begin n_bad++; $display("FAIL wrap_instr[%0d] got=%h want=%h", i, pop_instr[i], ~exp_seq[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        repeat (6) tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full_valid got=%b want=1", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_full_req got=%b want=0", imem_req_valid); end
        #1;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req got=%b want=0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got=%b want=0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_instr got=%h want=0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_pc got=%h want=0", instr_pc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        instr_ready = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_restart_req got=%b want=1", imem_req_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart_addr got=%h want=0", imem_addr); end
        repeat (8) tick();
        n_cmp++;
        if (acc_addr.size() < 1 || pop_pc.size() < 1) begin
            n_bad++; $display("FAIL mid_restart_counts accepts=%0d pops=%0d want>=1/1", acc_addr.size(), pop_pc.size());
        end else begin
            n_cmp++; if (acc_addr[0] !== 32'h0) begin n_bad++; $display("FAIL mid_restart_first_addr got=%h want=0", acc_addr[0]); end
            n_cmp++; if (pop_pc[0] !== 32'h0) begin n_bad++; $display("FAIL mid_restart_first_pc got=%h want=0", pop_pc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_redirect_rsp();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
